// File: rtl/uc_pkg.sv
// Shared opcode map, FSM state encoding and WD3 source-select codes
// for the uc_seq sequencing control unit.
package uc_pkg;

    localparam logic [5:0] OP_NOP  = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000001;
    localparam logic [5:0] OP_JZ   = 6'b000010;
    localparam logic [5:0] OP_JNZ  = 6'b000011;
    localparam logic [5:0] OP_IN   = 6'b000100;
    localparam logic [5:0] OP_OUT  = 6'b000101;
    localparam logic [5:0] OP_HALT = 6'b000110;

    // Load-immediate occupies the whole opcode[5:2] = 0100 group
    localparam logic [3:0] OP_LI   = 4'b0100;

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_WAIT_IN  = 2'd1,
        S_WAIT_OUT = 2'd2,
        S_HALT     = 2'd3
    } state_t;

    localparam logic [1:0] SEL_ALU   = 2'b00;
    localparam logic [1:0] SEL_PORT  = 2'b01;
    localparam logic [1:0] SEL_STACK = 2'b10;
    localparam logic [1:0] SEL_IMM   = 2'b11;

endpackage

// File: rtl/io_watchdog.sv
// Cycle counter for the I/O wait states; expire flags the last allowed
// wait cycle so the sequencer can abandon a stuck handshake.
module io_watchdog
    import uc_pkg::*;
#(
    parameter int TO_W       = 8,
    parameter int IO_TIMEOUT = 200
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic run,
    output logic expire
);

    localparam logic [TO_W-1:0] LAST = TO_W'(IO_TIMEOUT - 1);

    logic [TO_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (run) begin
            count <= count + TO_W'(1);
        end
    end

    assign expire = run && (count == LAST);

endmodule

// File: rtl/uc_seq.sv
// Sequencing control unit for the 8-bit datapath: opcode decode plus
// stall states for port handshakes, an I/O watchdog and HALT/wake.
module uc_seq
    import uc_pkg::*;
#(
    parameter int TO_W       = 8,
    parameter int IO_TIMEOUT = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       z,
    input  logic       in_valid,
    input  logic       out_ack,
    input  logic       wake,
    output logic       pc_en,
    output logic       s_inc,
    output logic       we3,
    output logic       wez,
    output logic       s_we_port,
    output logic [2:0] op_alu,
    output logic [1:0] sel_inputs,
    output logic       in_req,
    output logic       halted,
    output logic       io_timeout,
    output logic       illegal_op
);

    state_t state;
    state_t next_state;
    logic   in_wait;
    logic   expire;
    logic   set_timeout;
    logic   timeout_q;
    logic   we3_raw;
    logic   wez_raw;
    logic   we_port_raw;

    assign in_wait = (state == S_WAIT_IN) || (state == S_WAIT_OUT);

    io_watchdog #(
        .TO_W       (TO_W),
        .IO_TIMEOUT (IO_TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clr    (!in_wait),
        .run    (in_wait),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_RUN;
            timeout_q <= 1'b0;
        end else begin
            state <= next_state;
            if (set_timeout) begin
                timeout_q <= 1'b1;
            end
        end
    end

    always_comb begin
        next_state  = state;
        pc_en       = 1'b0;
        s_inc       = 1'b1;
        we3_raw     = 1'b0;
        wez_raw     = 1'b0;
        we_port_raw = 1'b0;
        op_alu      = opcode[4:2];
        sel_inputs  = SEL_ALU;
        in_req      = 1'b0;
        halted      = 1'b0;
        illegal_op  = 1'b0;
        set_timeout = 1'b0;

        unique case (state)
            S_RUN: begin
                pc_en = 1'b1;
                if (opcode[5]) begin
                    we3_raw = 1'b1;
                    wez_raw = 1'b1;
                end else if (opcode[5:2] == OP_LI) begin
                    we3_raw    = 1'b1;
                    sel_inputs = SEL_IMM;
                end else begin
                    case (opcode)
                        OP_NOP: ;
                        OP_J:   s_inc = 1'b0;
                        OP_JZ:  s_inc = ~z;
                        OP_JNZ: s_inc = z;
                        OP_IN: begin
                            if (in_valid) begin
                                we3_raw    = 1'b1;
                                sel_inputs = SEL_PORT;
                            end else begin
                                pc_en      = 1'b0;
                                in_req     = 1'b1;
                                next_state = S_WAIT_IN;
                            end
                        end
                        OP_OUT: begin
                            we_port_raw = 1'b1;
                            pc_en       = 1'b0;
                            next_state  = S_WAIT_OUT;
                        end
                        OP_HALT: begin
                            pc_en      = 1'b0;
                            next_state = S_HALT;
                        end
                        default: illegal_op = 1'b1;
                    endcase
                end
            end

            // A handshake arriving on the expiry cycle takes priority
            S_WAIT_IN: begin
                in_req = 1'b1;
                if (in_valid) begin
                    we3_raw    = 1'b1;
                    sel_inputs = SEL_PORT;
                    pc_en      = 1'b1;
                    next_state = S_RUN;
                end else if (expire) begin
                    set_timeout = 1'b1;
                    pc_en       = 1'b1;
                    next_state  = S_RUN;
                end
            end

            S_WAIT_OUT: begin
                if (out_ack) begin
                    pc_en      = 1'b1;
                    next_state = S_RUN;
                end else if (expire) begin
                    set_timeout = 1'b1;
                    pc_en       = 1'b1;
                    next_state  = S_RUN;
                end
            end

            S_HALT: begin
                halted = 1'b1;
                if (wake) begin
                    pc_en      = 1'b1;
                    next_state = S_RUN;
                end
            end

            default: next_state = S_RUN;
        endcase
    end

    // Reset suppresses every architectural write, including mid-wait aborts
    assign we3        = we3_raw & ~reset;
    assign wez        = wez_raw & ~reset;
    assign s_we_port  = we_port_raw & ~reset;
    assign io_timeout = timeout_q | (set_timeout & ~reset);

endmodule

// File: tb/tb_uc_seq.sv
// Scoreboard bench for uc_seq: directed vectors push hand-computed expected
// outputs; a negedge monitor pops and compares one entry per cycle.
module tb_uc_seq;
    import uc_pkg::*;

    typedef struct packed {
        logic       pc_en;
        logic       s_inc;
        logic       we3;
        logic       wez;
        logic       s_we_port;
        logic [2:0] op_alu;
        logic [1:0] sel;
        logic       in_req;
        logic       halted;
        logic       io_timeout;
        logic       illegal_op;
    } out_t;

    typedef struct {
        out_t        v;
        int unsigned dut;
        string       nm;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic       z;
    logic       in_valid;
    logic       out_ack;
    logic       wake;

    logic       pc_en0, s_inc0, we30, wez0, s_we_port0, in_req0, halted0, io_timeout0, illegal_op0;
    logic [2:0] op_alu0;
    logic [1:0] sel0;
    logic       pc_en1, s_inc1, we31, wez1, s_we_port1, in_req1, halted1, io_timeout1, illegal_op1;
    logic [2:0] op_alu1;
    logic [1:0] sel1;

    out_t act0;
    out_t act1;
    exp_t q[$];
    int   n_cmp;
    int   n_bad;

    assign act0 = {pc_en0, s_inc0, we30, wez0, s_we_port0, op_alu0, sel0, in_req0, halted0, io_timeout0, illegal_op0};
    assign act1 = {pc_en1, s_inc1, we31, wez1, s_we_port1, op_alu1, sel1, in_req1, halted1, io_timeout1, illegal_op1};

    uc_seq dut (
        .clk(clk), .reset(reset), .opcode(opcode), .z(z), .in_valid(in_valid),
        .out_ack(out_ack), .wake(wake), .pc_en(pc_en0), .s_inc(s_inc0), .we3(we30),
        .wez(wez0), .s_we_port(s_we_port0), .op_alu(op_alu0), .sel_inputs(sel0),
        .in_req(in_req0), .halted(halted0), .io_timeout(io_timeout0), .illegal_op(illegal_op0)
    );

    // Short-timeout instance for watchdog expiry checks
    uc_seq #(.TO_W(8), .IO_TIMEOUT(4)) dut_to (
        .clk(clk), .reset(reset), .opcode(opcode), .z(z), .in_valid(in_valid),
        .out_ack(out_ack), .wake(wake), .pc_en(pc_en1), .s_inc(s_inc1), .we3(we31),
        .wez(wez1), .s_we_port(s_we_port1), .op_alu(op_alu1), .sel_inputs(sel1),
        .in_req(in_req1), .halted(halted1), .io_timeout(io_timeout1), .illegal_op(illegal_op1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t base(input logic [5:0] op);
        out_t o;
        o        = '0;
        o.pc_en  = 1'b1;
        o.s_inc  = 1'b1;
        o.op_alu = op[4:2];
        return o;
    endfunction

    task automatic applyStimulus(input logic rst, input logic [5:0] op, input logic zz,
                                 input logic iv, input logic oa, input logic wk,
                                 input out_t v, input int unsigned d, input string nm);
        exp_t e;
        reset    = rst;
        opcode   = op;
        z        = zz;
        in_valid = iv;
        out_ack  = oa;
        wake     = wk;
        e.v      = v;
        e.dut    = d;
        e.nm     = nm;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input exp_t e);
        out_t a;
        a = (e.dut == 1) ? act1 : act0;
        n_cmp++;
        if (a !== e.v) begin
            n_bad++;
            $display("[TB] FAIL %s: got %b required %b (pc_en,s_inc,we3,wez,swp,alu3,sel2,in_req,halted,to,ill)",
                     e.nm, a, e.v);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        out_t o;
        n_cmp    = 0;
        n_bad    = 0;
        reset    = 1'b1;
        opcode   = 6'b101100;
        z        = 1'b0;
        in_valid = 1'b0;
        out_ack  = 1'b0;
        wake     = 1'b0;
        @(posedge clk);
        #1;

        // Reset held with an ALU opcode: writes forced low
        o = base(6'b101100);
        applyStimulus(1, 6'b101100, 0, 0, 0, 0, o, 0, "rst_hold_a");
        applyStimulus(1, 6'b101100, 0, 0, 0, 0, o, 0, "rst_hold_b");
        o = base(6'b101100); o.we3 = 1; o.wez = 1;
        applyStimulus(0, 6'b101100, 0, 0, 0, 0, o, 0, "alu_after_reset");

        // Branches
        o = base(OP_JZ);  o.s_inc = 0;
        applyStimulus(0, OP_JZ, 1, 0, 0, 0, o, 0, "jz_taken");
        o = base(OP_JZ);
        applyStimulus(0, OP_JZ, 0, 0, 0, 0, o, 0, "jz_not_taken");
        o = base(OP_JNZ);
        applyStimulus(0, OP_JNZ, 1, 0, 0, 0, o, 0, "jnz_not_taken");
        o = base(OP_JNZ); o.s_inc = 0;
        applyStimulus(0, OP_JNZ, 0, 0, 0, 0, o, 0, "jnz_taken");
        o = base(OP_J);   o.s_inc = 0;
        applyStimulus(0, OP_J, 1, 0, 0, 0, o, 0, "jump");
        o = base(6'b010011); o.we3 = 1; o.sel = SEL_IMM;
        applyStimulus(0, 6'b010011, 0, 0, 0, 0, o, 0, "load_imm");

        // IN stalls five cycles, then completes
        for (int i = 0; i < 5; i++) begin
            o = base(OP_IN); o.pc_en = 0; o.in_req = 1;
            applyStimulus(0, OP_IN, 0, 0, 0, 0, o, 0, "in_stall");
        end
        o = base(OP_IN); o.we3 = 1; o.sel = SEL_PORT; o.in_req = 1;
        applyStimulus(0, OP_IN, 0, 1, 0, 0, o, 0, "in_complete");
        o = base(OP_NOP);
        applyStimulus(0, OP_NOP, 0, 0, 0, 0, o, 0, "in_after_nop");
        o = base(OP_IN); o.we3 = 1; o.sel = SEL_PORT;
        applyStimulus(0, OP_IN, 0, 1, 0, 0, o, 0, "in_ready_now");

        // OUT acknowledged on cycle 3
        o = base(OP_OUT); o.s_we_port = 1; o.pc_en = 0;
        applyStimulus(0, OP_OUT, 0, 0, 0, 0, o, 0, "out_c0");
        o = base(OP_OUT); o.pc_en = 0;
        applyStimulus(0, OP_OUT, 0, 0, 0, 0, o, 0, "out_c1");
        applyStimulus(0, OP_OUT, 0, 0, 0, 0, o, 0, "out_c2");
        o = base(OP_OUT);
        applyStimulus(0, OP_OUT, 0, 0, 1, 0, o, 0, "out_c3_ack");

        // HALT ignores same-cycle wake, then wakes after 10 cycles
        o = base(OP_HALT); o.pc_en = 0;
        applyStimulus(0, OP_HALT, 0, 0, 0, 1, o, 0, "halt_decode");
        for (int i = 0; i < 10; i++) begin
            o = base(OP_HALT); o.pc_en = 0; o.halted = 1;
            applyStimulus(0, OP_HALT, 0, 0, 0, 0, o, 0, "halt_hold");
        end
        o = base(OP_HALT); o.halted = 1;
        applyStimulus(0, OP_HALT, 0, 0, 0, 1, o, 0, "halt_wake");
        o = base(OP_NOP);
        applyStimulus(0, OP_NOP, 0, 0, 0, 0, o, 0, "after_wake_run");

        // ALU upper corner and illegal opcodes
        o = base(6'b111111); o.we3 = 1; o.wez = 1;
        applyStimulus(0, 6'b111111, 0, 0, 0, 0, o, 0, "alu_111111");
        o = base(6'b001000); o.illegal_op = 1;
        applyStimulus(0, 6'b001000, 0, 0, 0, 0, o, 0, "illegal_001000");
        o = base(6'b000111); o.illegal_op = 1;
        applyStimulus(0, 6'b000111, 0, 0, 0, 0, o, 0, "illegal_000111");
        o = base(OP_NOP);
        applyStimulus(0, OP_NOP, 0, 0, 0, 0, o, 0, "illegal_clears");

        // Watchdog expiry on the IO_TIMEOUT=4 instance
        o = base(OP_NOP);
        applyStimulus(1, OP_NOP, 0, 0, 0, 0, o, 0, "rst_before_to");
        o = base(OP_OUT); o.s_we_port = 1; o.pc_en = 0;
        applyStimulus(0, OP_OUT, 0, 0, 0, 0, o, 1, "to_out_c0");
        for (int i = 0; i < 3; i++) begin
            o = base(OP_OUT); o.pc_en = 0;
            applyStimulus(0, OP_OUT, 0, 0, 0, 0, o, 1, "to_wait");
        end
        o = base(OP_OUT); o.io_timeout = 1;
        applyStimulus(0, OP_OUT, 0, 0, 0, 0, o, 1, "to_expire");
        o = base(OP_NOP); o.io_timeout = 1;
        applyStimulus(0, OP_NOP, 0, 0, 0, 0, o, 1, "to_sticky_a");
        applyStimulus(0, OP_NOP, 0, 0, 1, 0, o, 1, "to_sticky_b");
        o = base(OP_NOP);
        applyStimulus(1, OP_NOP, 0, 0, 0, 0, o, 0, "rst_clear_to");
        applyStimulus(0, OP_NOP, 0, 0, 0, 0, o, 1, "to_cleared");

        // Handshake on the expiry cycle wins
        o = base(OP_OUT); o.s_we_port = 1; o.pc_en = 0;
        applyStimulus(0, OP_OUT, 0, 0, 0, 0, o, 1, "race_out_c0");
        for (int i = 0; i < 3; i++) begin
            o = base(OP_OUT); o.pc_en = 0;
            applyStimulus(0, OP_OUT, 0, 0, 0, 0, o, 1, "race_wait");
        end
        o = base(OP_OUT);
        applyStimulus(0, OP_OUT, 0, 0, 1, 0, o, 1, "race_ack_at_expiry");
        o = base(OP_NOP);
        applyStimulus(0, OP_NOP, 0, 0, 0, 0, o, 1, "race_no_timeout");

        for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("[TB] FAIL drain: got %0d pending entries required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
